// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multi-cycle control: FSM states, opcodes,
// R-type function codes, ulaCore operation codes and ALU input selects.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    BRANCH  = 3'd5,
    TRAP    = 3'd6
  } ctrlStateT;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_LUI = 4'b1001;

  localparam logic [1:0] IN1_REG  = 2'd0;
  localparam logic [1:0] IN1_ZIMM = 2'd1;
  localparam logic [1:0] IN1_SIMM = 2'd2;

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// Combinational instruction decode: (opcode, funct) to ulaCore operation,
// ALU input selects and an illegal-instruction flag.
import mips_ctrl_pkg::*;

module alu_decode (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] aluOp,
  output logic [1:0] in1Sel,
  output logic       in2Sel,
  output logic       illegal
);

  always_comb begin
    aluOp   = ALU_AND;
    in1Sel  = IN1_REG;
    in2Sel  = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  aluOp = ALU_ADD;
          FN_SUB:  aluOp = ALU_SUB;
          FN_AND:  aluOp = ALU_AND;
          FN_OR:   aluOp = ALU_OR;
          FN_SLT:  aluOp = ALU_SLT;
          FN_SLL: begin
            aluOp  = ALU_SLL;
            in2Sel = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        aluOp  = ALU_ADD;
        in1Sel = IN1_SIMM;
      end
      OP_LUI: begin
        aluOp  = ALU_LUI;
        in1Sel = IN1_ZIMM;
      end
      OP_BEQ:  aluOp = ALU_SUB;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: one registered state drives every datapath
// select and strobe; data memory completes through mem_ready with a watchdog.
import mips_ctrl_pkg::*;

module multicycle_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic [1:0] alu_in1_sel,
  output logic       alu_in2_sel,
  output logic [3:0] alu_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       fault,
  output logic [2:0] state_dbg
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  ctrlStateT  stateReg, stateNext;
  logic       startedReg;
  logic [5:0] opcodeReg, functReg;
  logic [7:0] memTimerReg;

  logic       irWriteReg, pcWriteReg, aluIn2SelReg;
  logic [1:0] aluIn1SelReg;
  logic [3:0] aluOpReg;
  logic       memReadReg, memWriteReg, memToRegReg, regDstReg, regWriteReg, faultReg;

  logic [5:0] decOpcode, decFunct;
  logic [3:0] decAluOp;
  logic [1:0] decIn1Sel;
  logic       decIn2Sel, decIllegal;
  logic       nextIsLw, nextIsSw, nextIsRtype, aluActive;

  // In DECODE the live instruction bits are decoded so EXECUTE outputs can be
  // registered on the same edge that latches them.
  assign decOpcode = (stateReg == DECODE) ? opcode : opcodeReg;
  assign decFunct  = (stateReg == DECODE) ? funct  : functReg;

  alu_decode u_alu_decode (
    .opcode  (decOpcode),
    .funct   (decFunct),
    .aluOp   (decAluOp),
    .in1Sel  (decIn1Sel),
    .in2Sel  (decIn2Sel),
    .illegal (decIllegal)
  );

  assign nextIsLw    = (decOpcode == OP_LW);
  assign nextIsSw    = (decOpcode == OP_SW);
  assign nextIsRtype = (decOpcode == OP_RTYPE);

  always_comb begin
    stateNext = TRAP;
    case (stateReg)
      FETCH:   stateNext = DECODE;
      DECODE:  stateNext = decIllegal ? TRAP : ((opcode == OP_BEQ) ? BRANCH : EXECUTE);
      EXECUTE: stateNext = (nextIsLw || nextIsSw) ? MEM : WB;
      MEM: begin
        if (mem_ready)                      stateNext = nextIsLw ? WB : FETCH;
        else if (memTimerReg >= TIMEOUT_LAST) stateNext = TRAP;
        else                                stateNext = MEM;
      end
      WB, BRANCH: stateNext = FETCH;
      default:    stateNext = TRAP;
    endcase
  end

  // No ALU result register in this datapath, so ALU controls stay valid
  // through MEM and WB where the address/result is still consumed.
  assign aluActive = (stateNext == EXECUTE) || (stateNext == MEM) ||
                     (stateNext == WB) || (stateNext == BRANCH);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      stateReg     <= FETCH;
      startedReg   <= 1'b0;
      opcodeReg    <= '0;
      functReg     <= '0;
      memTimerReg  <= '0;
      irWriteReg   <= 1'b0;
      pcWriteReg   <= 1'b0;
      aluIn1SelReg <= IN1_REG;
      aluIn2SelReg <= 1'b0;
      aluOpReg     <= ALU_AND;
      memReadReg   <= 1'b0;
      memWriteReg  <= 1'b0;
      memToRegReg  <= 1'b0;
      regDstReg    <= 1'b0;
      regWriteReg  <= 1'b0;
      faultReg     <= 1'b0;
    end else if (!startedReg) begin
      // First cycle out of reset: present FETCH with its strobe asserted.
      startedReg <= 1'b1;
      irWriteReg <= 1'b1;
    end else begin
      stateReg <= stateNext;
      if (stateReg == DECODE) begin
        opcodeReg <= opcode;
        functReg  <= funct;
      end
      if (stateReg != MEM)
        memTimerReg <= '0;
      else if (memTimerReg != 8'hFF)
        memTimerReg <= memTimerReg + 8'd1;

      irWriteReg   <= (stateNext == FETCH);
      pcWriteReg   <= (stateNext == WB) || (stateNext == BRANCH);
      aluOpReg     <= aluActive ? decAluOp  : ALU_AND;
      aluIn1SelReg <= aluActive ? decIn1Sel : IN1_REG;
      aluIn2SelReg <= aluActive && decIn2Sel;
      memReadReg   <= (stateNext == MEM) && nextIsLw;
      memWriteReg  <= (stateNext == MEM) && nextIsSw;
      memToRegReg  <= (stateNext == WB) && nextIsLw;
      regDstReg    <= (stateNext == WB) && nextIsRtype;
      regWriteReg  <= (stateNext == WB);
      faultReg     <= faultReg || (stateNext == TRAP);
    end
  end

  assign ir_write    = irWriteReg;
  assign pc_write    = pcWriteReg || ((stateReg == MEM) && memWriteReg && mem_ready);
  assign pc_src      = (stateReg == BRANCH) && zero_flag;
  assign alu_in1_sel = aluIn1SelReg;
  assign alu_in2_sel = aluIn2SelReg;
  assign alu_op      = aluOpReg;
  assign mem_read    = memReadReg;
  assign mem_write   = memWriteReg;
  assign mem_to_reg  = memToRegReg;
  assign reg_dst     = regDstReg;
  assign reg_write   = regWriteReg;
  assign fault       = faultReg;
  assign state_dbg   = stateReg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: table of single-instruction vectors
// plus hand-written lw/sw/beq/timeout/reset sequences.
module tb_multicycle_control;

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
                         S_WB = 3'd4, S_BRANCH = 3'd5, S_TRAP = 3'd6;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero_flag = 1'b0, mem_ready = 1'b0;
  logic       ir_write, pc_write, pc_src, alu_in2_sel;
  logic [1:0] alu_in1_sel;
  logic [3:0] alu_op;
  logic       mem_read, mem_write, mem_to_reg, reg_dst, reg_write, fault;
  logic [2:0] state_dbg;

  always #5 clock = ~clock;

  multicycle_control #(.MEM_TIMEOUT(15)) dut (
    .clock(clock), .resetn(resetn), .opcode(opcode), .funct(funct),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_in1_sel(alu_in1_sel),
    .alu_in2_sel(alu_in2_sel), .alu_op(alu_op), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .fault(fault), .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic       irW, pcW, pcSrc;
    logic [1:0] in1;
    logic       in2;
    logic [3:0] op;
    logic       mr, mw, m2r, rdst, rw, flt;
    logic [2:0] st;
  } outsT;

  typedef struct {
    logic [5:0] op, fn;
    logic [3:0] alu;
    logic [1:0] in1;
    logic       in2, rdst, bad;
    string      name;
  } vecT;

  outsT act;
  assign act = {ir_write, pc_write, pc_src, alu_in1_sel, alu_in2_sel, alu_op,
                mem_read, mem_write, mem_to_reg, reg_dst, reg_write, fault, state_dbg};

  int   nChecks = 0, nFails = 0;
  vecT  vecs[10];
  outsT e;

  function automatic outsT at(input logic [2:0] st);
    outsT o = '0;
    o.st = st;
    return o;
  endfunction

  task automatic check(input string name, input outsT exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end else begin
      $display("ok   %s: %05h", name, act);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic resetAndFetch(input string name);
    outsT x;
    resetn = 1'b0;
    tick();
    check({name, " reset"}, at(S_FETCH));
    resetn = 1'b1;
    tick();
    x = at(S_FETCH);
    x.irW = 1'b1;
    check({name, " fetch"}, x);
  endtask

  function automatic outsT memOut(input logic isLw);
    outsT o = at(S_MEM);
    o.op  = 4'b0010;
    o.in1 = 2'd2;
    o.mr  = isLw;
    o.mw  = !isLw;
    return o;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{6'b000000, 6'b100000, 4'b0010, 2'd0, 1'b0, 1'b1, 1'b0, "add"};
    vecs[1] = '{6'b000000, 6'b100010, 4'b0110, 2'd0, 1'b0, 1'b1, 1'b0, "sub"};
    vecs[2] = '{6'b000000, 6'b100100, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, "and"};
    vecs[3] = '{6'b000000, 6'b100101, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0, "or"};
    vecs[4] = '{6'b000000, 6'b101010, 4'b0111, 2'd0, 1'b0, 1'b1, 1'b0, "slt"};
    vecs[5] = '{6'b000000, 6'b000000, 4'b1000, 2'd0, 1'b1, 1'b1, 1'b0, "sll"};
    vecs[6] = '{6'b001000, 6'b010101, 4'b0010, 2'd2, 1'b0, 1'b0, 1'b0, "addi"};
    vecs[7] = '{6'b001111, 6'b000000, 4'b1001, 2'd1, 1'b0, 1'b0, 1'b0, "lui"};
    vecs[8] = '{6'b111111, 6'b100000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, "badop"};
    vecs[9] = '{6'b000000, 6'b000001, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, "badfn"};

    for (int i = 0; i < 10; i++) begin
      opcode = vecs[i].op;
      funct  = vecs[i].fn;
      resetAndFetch(vecs[i].name);
      tick();
      check({vecs[i].name, " decode"}, at(S_DECODE));
      tick();
      if (vecs[i].bad) begin
        e = at(S_TRAP);
        e.flt = 1'b1;
        check({vecs[i].name, " trap"}, e);
        tick();
        check({vecs[i].name, " trap_hold"}, e);
      end else begin
        e = at(S_EXEC);
        e.op = vecs[i].alu; e.in1 = vecs[i].in1; e.in2 = vecs[i].in2;
        check({vecs[i].name, " exec"}, e);
        tick();
        e.st = S_WB; e.rw = 1'b1; e.pcW = 1'b1; e.rdst = vecs[i].rdst;
        check({vecs[i].name, " wb"}, e);
        tick();
        e = at(S_FETCH);
        e.irW = 1'b1;
        check({vecs[i].name, " next_fetch"}, e);
      end
    end

    // lw: mem_ready high before MEM (ignored), then low for 3 MEM cycles
    opcode = 6'b100011; funct = 6'b000111; mem_ready = 1'b1;
    resetAndFetch("lw");
    tick();
    check("lw decode", at(S_DECODE));
    tick();
    e = at(S_EXEC); e.op = 4'b0010; e.in1 = 2'd2;
    check("lw exec", e);
    mem_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("lw mem_wait%0d", k), memOut(1'b1));
    end
    tick();
    mem_ready = 1'b1;
    #1;
    check("lw mem_done", memOut(1'b1));
    tick();
    mem_ready = 1'b0;
    e = at(S_WB); e.op = 4'b0010; e.in1 = 2'd2; e.m2r = 1'b1; e.rw = 1'b1; e.pcW = 1'b1;
    check("lw wb", e);
    tick();
    e = at(S_FETCH); e.irW = 1'b1;
    check("lw next_fetch", e);

    // sw completing in its first MEM cycle
    opcode = 6'b101011;
    resetAndFetch("sw0");
    tick();
    tick();
    mem_ready = 1'b1;
    tick();
    e = memOut(1'b0); e.pcW = 1'b1;
    check("sw0 mem_done", e);
    tick();
    mem_ready = 1'b0;
    e = at(S_FETCH); e.irW = 1'b1;
    check("sw0 next_fetch", e);

    // beq with both zero_flag values; pc_src follows zero_flag combinationally
    for (int z = 1; z >= 0; z--) begin
      opcode = 6'b000100; funct = 6'b100000; zero_flag = z[0];
      resetAndFetch($sformatf("beq_z%0d", z));
      tick();
      check($sformatf("beq_z%0d decode", z), at(S_DECODE));
      tick();
      e = at(S_BRANCH); e.op = 4'b0110; e.pcW = 1'b1; e.pcSrc = z[0];
      check($sformatf("beq_z%0d branch", z), e);
      zero_flag = !z[0];
      #1;
      e.pcSrc = !z[0];
      check($sformatf("beq_z%0d branch_flip", z), e);
      tick();
      e = at(S_FETCH); e.irW = 1'b1;
      check($sformatf("beq_z%0d next_fetch", z), e);
    end
    zero_flag = 1'b0;

    // sw with mem_ready never asserted: 15 MEM cycles then TRAP
    opcode = 6'b101011; mem_ready = 1'b0;
    resetAndFetch("swto");
    tick();
    tick();
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("swto mem%0d", k), memOut(1'b0));
    end
    tick();
    e = at(S_TRAP); e.flt = 1'b1;
    check("swto trap", e);
    mem_ready = 1'b1;
    tick();
    check("swto trap_hold", e);
    mem_ready = 1'b0;
    resetn = 1'b0;
    tick();
    check("swto reset_clears", at(S_FETCH));
    resetn = 1'b1;
    tick();
    e = at(S_FETCH); e.irW = 1'b1;
    check("swto refetch", e);

    // reset asserted while lw waits in MEM
    opcode = 6'b100011;
    resetAndFetch("lwrst");
    tick();
    tick();
    tick();
    check("lwrst mem", memOut(1'b1));
    resetn = 1'b0;
    tick();
    check("lwrst aborted", at(S_FETCH));
    resetn = 1'b1;
    tick();
    e = at(S_FETCH); e.irW = 1'b1;
    check("lwrst refetch", e);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
